// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and pipeline_ctrl.
// The master modport is the datapath side; the slave modport is the controller side.
interface pipeline_ctrl_if;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    logic [REG_W-1:0] Rn_id;
    logic [REG_W-1:0] Rm_id;
    logic             uses_Rm_id;
    logic [REG_W-1:0] Rd_ex;
    logic             MemRead_ex;
    logic             BrTaken_mem;
    logic             mem_req_mem;
    logic             mem_ready;

    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             pc_sel_br;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output Rn_id, Rm_id, uses_Rm_id, Rd_ex, MemRead_ex, BrTaken_mem,
               mem_req_mem, mem_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_br,
               mem_timeout, stall_cnt
    );

    modport slave (
        input  Rn_id, Rm_id, uses_Rm_id, Rd_ex, MemRead_ex, BrTaken_mem,
               mem_req_mem, mem_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_br,
               mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, taken-branch flush,
// data-memory wait freeze with timeout to a sticky error state.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave p
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SCNT_W = 16;
    localparam int unsigned WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [REG_W-1:0]  XZR      = REG_W'(31);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [SCNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;
    logic                wait_exit_q, wait_exit_d;

    logic                lu_c;
    logic                mm_c;
    logic                advance_c;
    logic                pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c;
    logic                if_id_flush_c, id_ex_flush_c, ex_mem_flush_c;
    logic                pc_sel_br_c;

    // Hazard detection; the access that just completed is not seen again as a miss.
    always_comb begin
        lu_c = p.MemRead_ex && (p.Rd_ex != XZR) &&
               ((p.Rd_ex == p.Rn_id) || (p.uses_Rm_id && (p.Rd_ex == p.Rm_id)));
        mm_c = p.mem_req_mem && !p.mem_ready && !wait_exit_q;
    end

    // Next state, wait counter and pipeline register controls.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        wait_exit_d    = 1'b0;
        advance_c      = 1'b0;
        pc_we_c        = 1'b0;
        if_id_we_c     = 1'b0;
        id_ex_we_c     = 1'b0;
        ex_mem_we_c    = 1'b0;
        mem_wb_we_c    = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        pc_sel_br_c    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mm_c) begin
                    state_d    = WAIT;
                    wait_cnt_d = WCNT_ONE;
                end else begin
                    advance_c = 1'b1;
                end
            end
            WAIT: begin
                // The cycle memory completes lets the pipeline move on.
                if (p.mem_ready) begin
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                    wait_exit_d = 1'b1;
                    advance_c   = 1'b1;
                end else if (wait_cnt_q == WCNT_MAX) begin
                    state_d    = ERR;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_ONE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (advance_c) begin
            pc_we_c     = 1'b1;
            if_id_we_c  = 1'b1;
            id_ex_we_c  = 1'b1;
            ex_mem_we_c = 1'b1;
            mem_wb_we_c = 1'b1;
            if (p.BrTaken_mem) begin
                pc_sel_br_c    = 1'b1;
                if_id_flush_c  = 1'b1;
                id_ex_flush_c  = 1'b1;
                ex_mem_flush_c = 1'b1;
            end else if (lu_c) begin
                pc_we_c       = 1'b0;
                if_id_we_c    = 1'b0;
                id_ex_flush_c = 1'b1;
            end
        end

        // Reset holds every stage and loads bubbles everywhere.
        if (reset) begin
            pc_we_c        = 1'b0;
            if_id_we_c     = 1'b0;
            id_ex_we_c     = 1'b0;
            ex_mem_we_c    = 1'b0;
            mem_wb_we_c    = 1'b0;
            if_id_flush_c  = 1'b1;
            id_ex_flush_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
            pc_sel_br_c    = 1'b0;
        end

        stall_cnt_d   = (!pc_we_c && (stall_cnt_q != '1)) ? stall_cnt_q + SCNT_W'(1)
                                                          : stall_cnt_q;
        mem_timeout_d = mem_timeout_q || (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
            wait_exit_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            wait_exit_q   <= wait_exit_d;
        end
    end

    assign p.pc_we        = pc_we_c;
    assign p.if_id_we     = if_id_we_c;
    assign p.id_ex_we     = id_ex_we_c;
    assign p.ex_mem_we    = ex_mem_we_c;
    assign p.mem_wb_we    = mem_wb_we_c;
    assign p.if_id_flush  = if_id_flush_c;
    assign p.id_ex_flush  = id_ex_flush_c;
    assign p.ex_mem_flush = ex_mem_flush_c;
    assign p.pc_sel_br    = pc_sel_br_c;
    assign p.mem_timeout  = mem_timeout_q;
    assign p.stall_cnt    = stall_cnt_q;
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with clock and reset ports named as listed below.
REQ-002 Parameter TIMEOUT, default 255: maximum number of consecutive WAIT cycles before a timeout error is flagged.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- Rn_id  in  5  ID-stage source register A
- Rm_id  in  5  ID-stage source register B
- uses_Rm_id  in  1  ID instruction reads Rm
- Rd_ex  in  5  EX-stage destination register
- MemRead_ex  in  1  EX instruction is a load
- BrTaken_mem  in  1  branch resolved taken in MEM
- mem_req_mem  in  1  MEM stage is issuing a data-memory access
- mem_ready  in  1  data memory has completed the access this cycle
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID register enable
- id_ex_we  out  1  ID/EX register enable
- ex_mem_we  out  1  EX/MEM register enable
- mem_wb_we  out  1  MEM/WB register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- ex_mem_flush  out  1  load bubble into EX/MEM
- pc_sel_br  out  1  select branch target for PC
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  16  saturating count of non-advancing cycles

Function
REQ-004 State machine SHALL have states RUN, WAIT and ERR, with state register updated on the rising edge of clk.
REQ-005 Load-use hazard (lu) SHALL be defined combinationally as:
- MemRead_ex=1 AND Rd_ex!=31, AND
- (Rd_ex==Rn_id OR (uses_Rm_id=1 AND Rd_ex==Rm_id)).
REQ-006 Memory miss (mm) SHALL be defined combinationally as mem_req_mem=1 AND mem_ready=0.
REQ-007 Event priority SHALL be, highest first: reset, ERR, WAIT/mm freeze, BrTaken_mem, lu, normal advance.
REQ-008 Freeze SHALL apply in state WAIT, or in RUN when mm=1:
- all *_we=0;
- all flushes=0;
- pc_sel_br=0.
REQ-009 Branch, in RUN with mm=0 and BrTaken_mem=1:
- all *_we=1;
- pc_sel_br=1;
- if_id_flush=1, id_ex_flush=1, ex_mem_flush=1;
- lu is ignored.
REQ-010 Load-use, in RUN with mm=0, BrTaken_mem=0 and lu=1:
- pc_we=0, if_id_we=0;
- id_ex_we=1 with id_ex_flush=1;
- ex_mem_we=1, mem_wb_we=1;
- stall lasts exactly one cycle per lu occurrence.
REQ-011 Normal advance: in RUN with no event, all *_we=1, all flushes=0, pc_sel_br=0.
REQ-012 State transitions SHALL be:
- RUN->WAIT when mm=1;
- WAIT->RUN on the cycle mem_ready=1;
- the cycle after WAIT exit, the stalled access is not re-evaluated as mm (mem_req_mem is already satisfied).
REQ-013 While WAIT is entered, a wait counter SHALL reset to 1 and increment each WAIT cycle.
REQ-014 When the wait counter reaches TIMEOUT with mem_ready=0, the next state SHALL be ERR.
REQ-015 If mem_ready=1 arrives on the same cycle the wait counter reaches TIMEOUT, the next state SHALL be RUN and no error is raised.
REQ-016 ERR SHALL be held until reset:
- all *_we=0;
- mem_timeout=1.
REQ-017 stall_cnt SHALL increment by 1 on every cycle where pc_we=0 (freeze, load-use, ERR), and SHALL saturate at 16'hFFFF without wrap.
REQ-018 Write enables and flushes SHALL be combinational from state and inputs; state, wait counter, stall_cnt and mem_timeout SHALL be registered.

Reset
REQ-019 While reset=1:
- all *_we=0;
- all flushes=1;
- pc_sel_br=0.
REQ-020 On reset: state=RUN, wait counter=0, stall_cnt=0, mem_timeout=0, effective on the next rising edge.
REQ-021 Reset asserted in WAIT or ERR SHALL return the block to RUN with no residual stall.

Verification
REQ-022 Load-use: MemRead_ex=1, Rd_ex=5, Rn_id=5 for one cycle -> pc_we=0, if_id_we=0, id_ex_flush=1 for that cycle only; stall_cnt=1.
REQ-023 X31 exemption: MemRead_ex=1, Rd_ex=31, Rm_id=31, uses_Rm_id=1 -> no stall, all *_we=1.
REQ-024 Branch/hazard collision: BrTaken_mem=1 together with lu=1 -> pc_sel_br=1, three flushes=1, pc_we=1, stall_cnt unchanged.
REQ-025 Memory wait: mem_req_mem=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all *_we=0 for 3 cycles, back to RUN, stall_cnt=3.
REQ-026 Timeout: TIMEOUT=4, mem_ready held 0 -> ERR after 4 WAIT cycles, mem_timeout=1 stays set; reset then clears it.
REQ-027 Saturation: force 70000 freeze cycles (TIMEOUT large) -> stall_cnt=16'hFFFF with no wrap.
